// File: rtl/chase_pkg.sv
// Shared types and constants for the chasing-LED monitor: FSM states,
// error codes and the LED bank width.
package chase_pkg;

    localparam int LED_N = 16;
    localparam int POS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOCK     = 2'd1,
        ST_TRACK_UP = 2'd2,
        ST_TRACK_DN = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ONEHOT  = 2'd1;
    localparam logic [1:0] ERR_JUMP    = 2'd2;
    localparam logic [1:0] ERR_REVERSE = 2'd3;

endpackage

// File: rtl/onehot_enc.sv
// Combinational 16-to-4 encoder; valid is high only when exactly one LED is lit.
module onehot_enc
    import chase_pkg::*;
(
    input  logic [LED_N-1:0] led,
    output logic [POS_W-1:0] idx,
    output logic             valid
);

    logic [POS_W:0] ones_s;

    // Count lit LEDs and remember the index of the highest one seen.
    always_comb begin
        ones_s = 5'd0;
        idx    = 4'd0;
        for (int i = 0; i < LED_N; i++) begin
            if (led[i]) begin
                ones_s = ones_s + 5'd1;
                idx    = 4'(i);
            end else begin
                ones_s = ones_s;
            end
        end
        valid = (ones_s == 5'd1);
    end

endmodule

// File: rtl/chase_monitor.sv
// Tracks a single lit LED sweeping back and forth, flagging stalls, counting
// end reversals and latching the first protocol error since the last clear.
module chase_monitor
    import chase_pkg::*;
#(
    parameter int STALL_LIM = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample,
    input  logic [LED_N-1:0]     led_in,
    input  logic                 clear,
    output logic [POS_W-1:0]     pos,
    output logic                 pos_valid,
    output logic                 dir,
    output logic                 locked,
    output logic                 stalled,
    output logic [CNT_W-1:0]     bounce_cnt,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam logic [7:0]       STALL_MAX  = 8'(STALL_LIM);
    localparam logic [CNT_W-1:0] BOUNCE_MAX = {CNT_W{1'b1}};

    logic [POS_W-1:0] n_s;
    logic             onehot_s;

    state_e           state_r,      state_nxt_s;
    logic [POS_W-1:0] pos_r,        pos_nxt_s;
    logic             pos_valid_r,  pos_valid_nxt_s;
    logic             dir_r,        dir_nxt_s;
    logic             locked_r,     locked_nxt_s;
    logic             stalled_r,    stalled_nxt_s;
    logic [7:0]       stall_cnt_r,  stall_cnt_nxt_s;
    logic [CNT_W-1:0] bounce_cnt_r, bounce_cnt_nxt_s;
    logic             err_r,        err_nxt_s;
    logic [1:0]       err_code_r,   err_code_nxt_s;

    logic             err_hit_s;
    logic [1:0]       err_new_s;
    logic             bounce_hit_s;
    logic             step_up_s;
    logic             step_dn_s;
    logic             same_s;

    onehot_enc u_enc (
        .led   (led_in),
        .idx   (n_s),
        .valid (onehot_s)
    );

    // Five-bit compares so that 15+1 and 0-1 never alias onto a real index.
    assign step_up_s = (({1'b0, pos_r} + 5'd1) == {1'b0, n_s});
    assign step_dn_s = (({1'b0, n_s} + 5'd1) == {1'b0, pos_r});
    assign same_s    = (n_s == pos_r);

    // Next-state and next-output logic for one qualified sample.
    always_comb begin
        state_nxt_s     = state_r;
        pos_nxt_s       = pos_r;
        pos_valid_nxt_s = pos_valid_r;
        dir_nxt_s       = dir_r;
        stall_cnt_nxt_s = stall_cnt_r;
        err_hit_s       = 1'b0;
        err_new_s       = ERR_NONE;
        bounce_hit_s    = 1'b0;

        if (!sample) begin
            state_nxt_s = state_r;
        end else if (!onehot_s) begin
            err_hit_s       = 1'b1;
            err_new_s       = ERR_ONEHOT;
            pos_valid_nxt_s = 1'b0;
            stall_cnt_nxt_s = 8'd0;
            state_nxt_s     = ST_IDLE;
        end else begin
            pos_nxt_s       = n_s;
            pos_valid_nxt_s = 1'b1;
            if (pos_valid_r && same_s) begin
                stall_cnt_nxt_s = (stall_cnt_r == STALL_MAX) ? stall_cnt_r : stall_cnt_r + 8'd1;
            end else begin
                stall_cnt_nxt_s = 8'd0;
            end

            case (state_r)
                ST_IDLE: state_nxt_s = ST_LOCK;
                ST_LOCK: begin
                    if (same_s) begin
                        state_nxt_s = ST_LOCK;
                    end else if (step_up_s) begin
                        state_nxt_s = ST_TRACK_UP;
                        dir_nxt_s   = 1'b0;
                    end else if (step_dn_s) begin
                        state_nxt_s = ST_TRACK_DN;
                        dir_nxt_s   = 1'b1;
                    end else begin
                        err_hit_s   = 1'b1;
                        err_new_s   = ERR_JUMP;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_TRACK_UP: begin
                    if (step_up_s || same_s) begin
                        state_nxt_s = ST_TRACK_UP;
                    end else if (pos_r == 4'd15 && n_s == 4'd14) begin
                        state_nxt_s  = ST_TRACK_DN;
                        dir_nxt_s    = 1'b1;
                        bounce_hit_s = 1'b1;
                    end else begin
                        err_hit_s   = 1'b1;
                        err_new_s   = step_dn_s ? ERR_REVERSE : ERR_JUMP;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_TRACK_DN: begin
                    if (step_dn_s || same_s) begin
                        state_nxt_s = ST_TRACK_DN;
                    end else if (pos_r == 4'd0 && n_s == 4'd1) begin
                        state_nxt_s  = ST_TRACK_UP;
                        dir_nxt_s    = 1'b0;
                        bounce_hit_s = 1'b1;
                    end else begin
                        err_hit_s   = 1'b1;
                        err_new_s   = step_up_s ? ERR_REVERSE : ERR_JUMP;
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Sticky error and bounce counter; a same-cycle event beats clear.
    always_comb begin
        if (err_hit_s) begin
            err_nxt_s      = 1'b1;
            err_code_nxt_s = (!err_r || clear) ? err_new_s : err_code_r;
        end else if (clear) begin
            err_nxt_s      = 1'b0;
            err_code_nxt_s = ERR_NONE;
        end else begin
            err_nxt_s      = err_r;
            err_code_nxt_s = err_code_r;
        end

        if (bounce_hit_s) begin
            if (clear) begin
                bounce_cnt_nxt_s = CNT_W'(1);
            end else if (bounce_cnt_r == BOUNCE_MAX) begin
                bounce_cnt_nxt_s = bounce_cnt_r;
            end else begin
                bounce_cnt_nxt_s = bounce_cnt_r + CNT_W'(1);
            end
        end else if (clear) begin
            bounce_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            bounce_cnt_nxt_s = bounce_cnt_r;
        end

        locked_nxt_s  = (state_nxt_s == ST_TRACK_UP) || (state_nxt_s == ST_TRACK_DN);
        stalled_nxt_s = (stall_cnt_nxt_s == STALL_MAX);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            pos_r        <= 4'd0;
            pos_valid_r  <= 1'b0;
            dir_r        <= 1'b0;
            locked_r     <= 1'b0;
            stalled_r    <= 1'b0;
            stall_cnt_r  <= 8'd0;
            bounce_cnt_r <= {CNT_W{1'b0}};
            err_r        <= 1'b0;
            err_code_r   <= ERR_NONE;
        end else begin
            state_r      <= state_nxt_s;
            pos_r        <= pos_nxt_s;
            pos_valid_r  <= pos_valid_nxt_s;
            dir_r        <= dir_nxt_s;
            locked_r     <= locked_nxt_s;
            stalled_r    <= stalled_nxt_s;
            stall_cnt_r  <= stall_cnt_nxt_s;
            bounce_cnt_r <= bounce_cnt_nxt_s;
            err_r        <= err_nxt_s;
            err_code_r   <= err_code_nxt_s;
        end
    end

    assign pos        = pos_r;
    assign pos_valid  = pos_valid_r;
    assign dir        = dir_r;
    assign locked     = locked_r;
    assign stalled    = stalled_r;
    assign bounce_cnt = bounce_cnt_r;
    assign err        = err_r;
    assign err_code   = err_code_r;

endmodule

// File: tb/tb_chase_monitor.sv
// Self-checking bench for chase_monitor: directed scenarios plus random
// traffic, all compared against a behavioural model of the tracking rules.
module tb_chase_monitor;

    localparam int LIM  = 4;
    localparam int CW   = 8;
    localparam int BMAX = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample = 1'b0;
    logic [15:0] led_in = 16'h0000;
    logic        clear = 1'b0;
    logic [3:0]  pos;
    logic        pos_valid;
    logic        dir;
    logic        locked;
    logic        stalled;
    logic [CW-1:0] bounce_cnt;
    logic        err;
    logic [1:0]  err_code;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Model state: mode 0 idle, 1 lock, 2 moving up, 3 moving down.
    int m_mode, m_pos, m_pv, m_dir, m_stall, m_bounce, m_err, m_code;

    chase_monitor #(.STALL_LIM(LIM), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample     (sample),
        .led_in     (led_in),
        .clear      (clear),
        .pos        (pos),
        .pos_valid  (pos_valid),
        .dir        (dir),
        .locked     (locked),
        .stalled    (stalled),
        .bounce_cnt (bounce_cnt),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit smp, input logic [15:0] led, input bit clr);
        int ecode, n, d;
        bit bnc;
        ecode = 0;
        bnc   = 1'b0;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_pv = 0; m_dir = 0;
            m_stall = 0; m_bounce = 0; m_err = 0; m_code = 0;
            return;
        end
        if (smp) begin
            if ($countones(led) != 1) begin
                ecode = 1; m_pv = 0; m_stall = 0;
            end else begin
                n = 0;
                for (int i = 0; i < 16; i++) if (led[i]) n = i;
                d = n - m_pos;
                m_stall = (m_pv != 0 && d == 0) ? ((m_stall < LIM) ? m_stall + 1 : LIM) : 0;
                case (m_mode)
                    0: m_mode = 1;
                    1: begin
                        if (d == 1) begin m_mode = 2; m_dir = 0; end
                        else if (d == -1) begin m_mode = 3; m_dir = 1; end
                        else if (d != 0) ecode = 2;
                    end
                    2: begin
                        if (m_pos == 15 && n == 14) begin m_mode = 3; m_dir = 1; bnc = 1'b1; end
                        else if (d == -1) ecode = 3;
                        else if (d != 0 && d != 1) ecode = 2;
                    end
                    default: begin
                        if (m_pos == 0 && n == 1) begin m_mode = 2; m_dir = 0; bnc = 1'b1; end
                        else if (d == 1) ecode = 3;
                        else if (d != 0 && d != -1) ecode = 2;
                    end
                endcase
                m_pos = n;
                m_pv  = 1;
            end
            if (ecode != 0) m_mode = 0;
        end
        if (ecode != 0) begin
            if (m_err == 0 || clr) m_code = ecode;
            m_err = 1;
        end else if (clr) begin
            m_err = 0; m_code = 0;
        end
        if (bnc) m_bounce = clr ? 1 : ((m_bounce < BMAX) ? m_bounce + 1 : BMAX);
        else if (clr) m_bounce = 0;
    endtask

    task automatic step(input bit rst, input bit smp, input logic [15:0] led, input bit clr);
        reset  = rst;
        sample = smp;
        led_in = led;
        clear  = clr;
        model_step(rst, smp, led, clr);
        @(posedge clk);
        #1;
        check_eq("pos",        int'(pos),        m_pos);
        check_eq("pos_valid",  int'(pos_valid),  m_pv);
        check_eq("dir",        int'(dir),        m_dir);
        check_eq("locked",     int'(locked),     (m_mode >= 2) ? 1 : 0);
        check_eq("stalled",    int'(stalled),    (m_stall == LIM) ? 1 : 0);
        check_eq("bounce_cnt", int'(bounce_cnt), m_bounce);
        check_eq("err",        int'(err),        m_err);
        check_eq("err_code",   int'(err_code),   m_code);
    endtask

    task automatic put(input int n);
        logic [15:0] v;
        v = 16'h0001 << n;
        step(1'b0, 1'b1, v, 1'b0);
    endtask

    initial begin
        logic [15:0] v;
        int n, r;

        step(1'b1, 1'b0, 16'h0000, 1'b0);
        check_eq("reset_err", int'(err), 0);

        // Basic lock-on and upward tracking.
        put(0); put(1); put(2);
        check_eq("lock_pos2", int'(pos), 2);
        check_eq("lock_locked", int'(locked), 1);

        // Full sweep with both end reversals.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 16; i++) put(i);
        put(14);
        check_eq("bounce_top", int'(bounce_cnt), 1);
        for (int i = 13; i >= 0; i--) put(i);
        put(1);
        check_eq("bounce_bot", int'(bounce_cnt), 2);

        // Early reversal, then first error retained.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i <= 5; i++) put(i);
        put(4);
        check_eq("early_rev", int'(err_code), 3);
        put(10);
        check_eq("first_err_kept", int'(err_code), 3);

        // Not-one-hot and wrap-around errors.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h0003, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        put(7);
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 16; i++) put(i);
        put(0);
        check_eq("wrap_err", int'(err_code), 2);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        put(1); put(0); put(15);

        // Stall detection, saturation and idle cycles.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        put(0); put(1); put(2); put(3);
        for (int i = 0; i < 6; i++) put(3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'($urandom), 1'b0);
        put(4);

        // Clear colliding with an error and with a bounce; reset mid-sweep.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        put(0); put(1); put(2);
        step(1'b0, 1'b1, 16'h0100, 1'b1);
        check_eq("clr_vs_err", int'(err_code), 2);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        put(0); put(1); put(9);
        step(1'b0, 1'b1, 16'h0003, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 16; i++) put(i);
        step(1'b0, 1'b1, 16'h4000, 1'b0);
        put(13);
        step(1'b0, 1'b1, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 16; i++) put(i);
        step(1'b0, 1'b1, 16'h4000, 1'b1);
        check_eq("clr_vs_bounce", int'(bounce_cnt), 1);
        put(13); put(12);
        step(1'b1, 1'b1, 16'h0800, 1'b0);

        // Long sweeps to push the bounce counter into saturation.
        put(0);
        for (int k = 0; k < 130; k++) begin
            for (int i = 1; i < 16; i++) put(i);
            for (int i = 14; i >= 0; i--) put(i);
        end
        check_eq("bounce_sat", int'(bounce_cnt), BMAX);

        // Random traffic biased towards legal steps.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 35)      n = m_pos + 1;
            else if (r < 70) n = m_pos - 1;
            else if (r < 85) n = m_pos;
            else             n = int'($urandom_range(0, 15));
            n = n & 15;
            v = 16'h0001 << n;
            if ($urandom_range(0, 24) == 0) v = 16'($urandom);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, v,
                 $urandom_range(0, 29) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
